mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter FUNCT_W, default 6, width of the funct field and alu_funct; legal values >= 6.
REQ-002 SHALL have parameter MEM_WAIT_MAX, default 15, the maximum number of cycles spent waiting on mem_ready before abort; range 1..255.
REQ-003 SHALL have port clock  in  1  system clock, rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports opcode in 6 (instruction opcode); funct in FUNCT_W (R-type function code); zero in 1 (ALU zero flag); mem_ready in 1 (memory access done).
REQ-006 SHALL have output ports pc_load, ir_load, reg_write, mem_read, mem_write, each 1 bit, each a strobe for its named action.
REQ-007 SHALL have output port alu_funct, FUNCT_W bits, giving the ALU operation.
REQ-008 SHALL have 1-bit output mux selects:
- rd_mux_s: 1=rd, 0=rt.
- op2_mux_s: 1=immediate.
- wb_mux_s: 1=memory data.
- branch_mux_s: 1=branch target.
- j_mux_s: 1=jump target.
- link_s: 1=write PC+4 to r31.
REQ-009 SHALL have output ports illegal (1 bit, one-cycle pulse) and state_o (3 bits, current state).

Function
REQ-010 SHALL implement states IF=0, ID=1, EX=2, MA=3, WB=4; codes 5..7 SHALL go to IF on the next edge.
REQ-011 SHALL decode outputs combinationally from the state register, the op class latched in ID, and the funct latched in ID; zero and mem_ready are the only inputs used directly.
REQ-012 IF SHALL assert mem_read and hold until mem_ready=1; in that cycle it SHALL assert ir_load and go to ID.
REQ-013 ID SHALL latch the op class and funct.
- R (000000), ADDI (001000), LW (100011), SW (101011), BEQ (000100), BNE (000101): go to EX.
- J (000010): assert pc_load and j_mux_s, go to IF.
- Any other opcode: pulse illegal, assert pc_load (skip the instruction), go to IF.
REQ-014 alu_funct in EX/MA/WB SHALL be the latched funct for R; 100000 (zero-extended) for ADDI/LW/SW; 100010 for BEQ/BNE; 0 in all other states.
REQ-015 EX: R and ADDI SHALL go to WB; LW and SW SHALL go to MA; BEQ/BNE SHALL assert pc_load and go to IF.
- branch_mux_s = zero for BEQ; ~zero for BNE.
- op2_mux_s=1 for ADDI/LW/SW.
REQ-016 MA SHALL assert mem_read (LW) or mem_write (SW) until mem_ready=1.
- LW then goes to WB.
- SW asserts pc_load in that cycle and goes to IF.
REQ-017 WB SHALL assert reg_write and pc_load for exactly one cycle, then go to IF.
- rd_mux_s=1 only for R.
- wb_mux_s=1 only for LW.
REQ-018 Latency with mem_ready tied high SHALL be: J 2 cycles; BEQ/BNE 3; R/ADDI/SW 4; LW 5.
REQ-019 A wait in IF or MA reaching MEM_WAIT_MAX cycles without mem_ready SHALL pulse illegal, drop the strobe, and go to IF without pc_load.
- The wait counter SHALL clear on every state change.
REQ-020 pc_load SHALL be asserted in exactly one cycle per completed instruction and never together with ir_load.

Reset
REQ-021 While reset=1 every output SHALL be 0 and state_o SHALL be IF; the latched class, funct, and wait counter SHALL clear.
REQ-022 Reset mid-instruction SHALL abort it with no reg_write, mem_write, or pc_load.
- After release, the first cycle SHALL be IF with mem_read=1.

Configuration
REQ-023 Macro MC_CONTROL_JAL_EN defined: JAL (000011) SHALL go ID->WB.
- WB for JAL asserts reg_write, link_s, j_mux_s, and pc_load.
- Latency is 3 cycles.
REQ-024 Macro undefined: link_s SHALL be tied to 0 and JAL SHALL be treated as illegal.

Structure
REQ-025 Package mc_pkg SHALL hold:
- opcode and funct constants;
- the state enum (3 bits);
- the op-class enum (R, ADDI, LW, SW, BEQ, BNE, J, JAL, ILL).
REQ-026 A combinational sub-module mc_decode SHALL map opcode to op class; mc_control SHALL instantiate it once.

Verification
REQ-027 With mem_ready=1: R funct=100010 -> states 0,1,2,4; alu_funct=100010 in EX; reg_write=1 and rd_mux_s=1 in WB; pc_load in cycle 4 only.
REQ-028 LW with mem_ready low 3 cycles in MA -> mem_read held 4 MA cycles; then WB with wb_mux_s=1 and reg_write=1; total 8 cycles.
REQ-029 BNE with zero=1 -> branch_mux_s=0 and pc_load=1 in EX; BEQ with zero=1 -> branch_mux_s=1; both 3 cycles.
REQ-030 opcode=111111 -> illegal=1 for one cycle in ID with pc_load=1, no reg_write; JAL without the macro behaves the same.
REQ-031 mem_ready held 0 in IF with MEM_WAIT_MAX=4 -> illegal pulses after 4 cycles, state returns to IF, no ir_load.
REQ-032 reset asserted during SW MA -> mem_write drops the same cycle, no pc_load, IF after release.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_control shared definitions: opcodes, funct codes, FSM states and op classes.
// The JAL op class only decodes when MC_CONTROL_JAL_EN is defined.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;

  typedef enum logic [2:0] {
    S_IF = 3'd0,
    S_ID = 3'd1,
    S_EX = 3'd2,
    S_MA = 3'd3,
    S_WB = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_ADDI, C_LW, C_SW, C_BEQ,
    C_BNE, C_J, C_JAL, C_ILL
  } opclass_e;

  typedef struct packed {
    logic pc_load;
    logic ir_load;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic rd_mux_s;
    logic op2_mux_s;
    logic wb_mux_s;
    logic branch_mux_s;
    logic j_mux_s;
    logic link_s;
    logic illegal;
  } ctl_t;

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath bundle: instruction fields and status in,
// strobes, mux selects and ALU function out.
interface mc_control_if #(
  parameter int FUNCT_W = 6
);

  logic [5:0]         opcode;
  logic [FUNCT_W-1:0] funct;
  logic               zero;
  logic               mem_ready;

  logic               pc_load;
  logic               ir_load;
  logic               reg_write;
  logic               mem_read;
  logic               mem_write;
  logic [FUNCT_W-1:0] alu_funct;
  logic               rd_mux_s;
  logic               op2_mux_s;
  logic               wb_mux_s;
  logic               branch_mux_s;
  logic               j_mux_s;
  logic               link_s;
  logic               illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_load, ir_load, reg_write,
    output mem_read, mem_write, alu_funct,
    output rd_mux_s, op2_mux_s, wb_mux_s,
    output branch_mux_s, j_mux_s, link_s,
    output illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_load, ir_load, reg_write,
    input  mem_read, mem_write, alu_funct,
    input  rd_mux_s, op2_mux_s, wb_mux_s,
    input  branch_mux_s, j_mux_s, link_s,
    input  illegal
  );

endinterface

// File: rtl/mc_decode.sv
// Opcode to op-class decoder (combinational).
// JAL decodes only when MC_CONTROL_JAL_EN is defined.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  output opclass_e   cls_o
);

  always_comb begin
    cls_o = C_ILL;
    unique case (opcode_i)
      OP_R:    cls_o = C_R;
      OP_ADDI: cls_o = C_ADDI;
      OP_LW:   cls_o = C_LW;
      OP_SW:   cls_o = C_SW;
      OP_BEQ:  cls_o = C_BEQ;
      OP_BNE:  cls_o = C_BNE;
      OP_J:    cls_o = C_J;
`ifdef MC_CONTROL_JAL_EN
      OP_JAL:  cls_o = C_JAL;
`endif
      default: cls_o = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM (IF/ID/EX/MA/WB) with memory wait timeout.
// Define MC_CONTROL_JAL_EN to enable JAL (ID->WB with link).
module mc_control
  import mc_pkg::*;
#(
  parameter int FUNCT_W      = 6,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic          clock,
  input  logic          reset,
  mc_control_if.master  bus,
  output logic [2:0]    state_o
);

  localparam logic [7:0] WAIT_LIM = 8'(MEM_WAIT_MAX);

  state_e             state_q, state_d;
  opclass_e           cls_q, cls_d, dec_cls;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic [FUNCT_W-1:0] alu_op, alu;
  logic [7:0]         wait_q, wait_d;
  logic               timeout;
  ctl_t               c;

  mc_decode u_dec (
    .opcode_i (bus.opcode),
    .cls_o    (dec_cls)
  );

  assign timeout = (wait_q == WAIT_LIM);

  always_comb begin
    alu_op = '0;
    unique case (cls_q)
      C_R:                 alu_op = funct_q;
      C_ADDI, C_LW, C_SW:  alu_op = FUNCT_W'(FN_ADD);
      C_BEQ, C_BNE:        alu_op = FUNCT_W'(FN_SUB);
      default:             alu_op = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    funct_d = funct_q;
    wait_d  = '0;
    c       = '0;
    alu     = '0;
    unique case (state_q)
      S_IF: begin
        if (timeout) begin
          c.illegal = 1'b1;
          state_d   = S_IF;
        end else begin
          c.mem_read = 1'b1;
          if (bus.mem_ready) begin
            c.ir_load = 1'b1;
            state_d   = S_ID;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      S_ID: begin
        cls_d   = dec_cls;
        funct_d = bus.funct;
        unique case (dec_cls)
          C_J: begin
            c.pc_load = 1'b1;
            c.j_mux_s = 1'b1;
            state_d   = S_IF;
          end
          C_JAL: state_d = S_WB;
          C_ILL: begin
            c.illegal = 1'b1;
            c.pc_load = 1'b1;
            state_d   = S_IF;
          end
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        alu = alu_op;
        unique case (cls_q)
          C_R:    state_d = S_WB;
          C_ADDI: begin
            c.op2_mux_s = 1'b1;
            state_d     = S_WB;
          end
          C_LW, C_SW: begin
            c.op2_mux_s = 1'b1;
            state_d     = S_MA;
          end
          C_BEQ, C_BNE: begin
            c.branch_mux_s = (cls_q == C_BEQ) ? bus.zero : ~bus.zero;
            c.pc_load      = 1'b1;
            state_d        = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MA: begin
        alu = alu_op;
        if (timeout) begin
          c.illegal = 1'b1;
          state_d   = S_IF;
        end else begin
          c.mem_read  = (cls_q == C_LW);
          c.mem_write = (cls_q == C_SW);
          if (bus.mem_ready) begin
            c.pc_load = (cls_q == C_SW);
            state_d   = (cls_q == C_LW) ? S_WB : S_IF;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      S_WB: begin
        alu         = alu_op;
        c.reg_write = 1'b1;
        c.pc_load   = 1'b1;
        c.rd_mux_s  = (cls_q == C_R);
        c.wb_mux_s  = (cls_q == C_LW);
`ifdef MC_CONTROL_JAL_EN
        c.link_s    = (cls_q == C_JAL);
        c.j_mux_s   = (cls_q == C_JAL);
`endif
        state_d     = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      cls_q   <= C_R;
      funct_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      funct_q <= funct_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs are forced low while reset is held, even though state is IF.
  assign bus.pc_load      = ~reset & c.pc_load;
  assign bus.ir_load      = ~reset & c.ir_load;
  assign bus.reg_write    = ~reset & c.reg_write;
  assign bus.mem_read     = ~reset & c.mem_read;
  assign bus.mem_write    = ~reset & c.mem_write;
  assign bus.rd_mux_s     = ~reset & c.rd_mux_s;
  assign bus.op2_mux_s    = ~reset & c.op2_mux_s;
  assign bus.wb_mux_s     = ~reset & c.wb_mux_s;
  assign bus.branch_mux_s = ~reset & c.branch_mux_s;
  assign bus.j_mux_s      = ~reset & c.j_mux_s;
  assign bus.link_s       = ~reset & c.link_s;
  assign bus.illegal      = ~reset & c.illegal;
  assign bus.alu_funct    = reset ? '0 : alu;
  assign state_o          = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle expectations queued on drive,
// popped and compared on the falling edge.
module tb_mc_control;
  import mc_pkg::*;

  localparam logic [11:0] PC = 12'h800;
  localparam logic [11:0] IR = 12'h400;
  localparam logic [11:0] RW = 12'h200;
  localparam logic [11:0] MR = 12'h100;
  localparam logic [11:0] MW = 12'h080;
  localparam logic [11:0] RD = 12'h040;
  localparam logic [11:0] O2 = 12'h020;
  localparam logic [11:0] WB = 12'h010;
  localparam logic [11:0] BR = 12'h008;
  localparam logic [11:0] JM = 12'h004;
  localparam logic [11:0] LK = 12'h002;
  localparam logic [11:0] IL = 12'h001;
  localparam logic [11:0] NO = 12'h000;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [11:0] ctl;
    logic [5:0]  alu;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [2:0] state_o;
  logic [11:0] got;
  exp_t       sbq[$];
  exp_t       ce;
  int         total = 0;
  int         bad   = 0;

  mc_control_if #(.FUNCT_W(6)) bus ();

  mc_control #(
    .FUNCT_W      (6),
    .MEM_WAIT_MAX (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  assign got = {bus.pc_load, bus.ir_load, bus.reg_write,
                bus.mem_read, bus.mem_write, bus.rd_mux_s,
                bus.op2_mux_s, bus.wb_mux_s, bus.branch_mux_s,
                bus.j_mux_s, bus.link_s, bus.illegal};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input string tag, input logic r,
                     input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy,
                     input logic [2:0] st, input logic [11:0] ctl,
                     input logic [5:0] alu);
    exp_t e;
    @(posedge clock);
    #1;
    reset         = r;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = rdy;
    e.tag = tag;
    e.st  = st;
    e.ctl = ctl;
    e.alu = alu;
    sbq.push_back(e);
  endtask

  always @(negedge clock) begin
    if (sbq.size() != 0) begin
      ce = sbq.pop_front();
      check({ce.tag, ".state"}, 32'(state_o), 32'(ce.st));
      check({ce.tag, ".ctl"}, 32'(got), 32'(ce.ctl));
      check({ce.tag, ".alu"}, 32'(bus.alu_funct), 32'(ce.alu));
    end
  end

  initial begin
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.funct     = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    cyc("rst", 1, OP_R, 6'h00, 0, 1, 0, NO, 0);
    cyc("rst", 1, OP_R, 6'h00, 0, 1, 0, NO, 0);

    cyc("r", 0, OP_R, 6'h22, 0, 1, 0, MR|IR, 0);
    cyc("r", 0, OP_R, 6'h22, 0, 1, 1, NO, 0);
    cyc("r", 0, OP_R, 6'h00, 0, 1, 2, NO, 6'h22);
    cyc("r", 0, OP_R, 6'h00, 0, 1, 4, PC|RW|RD, 6'h22);

    cyc("addi", 0, OP_ADDI, 6'h07, 0, 1, 0, MR|IR, 0);
    cyc("addi", 0, OP_ADDI, 6'h07, 0, 1, 1, NO, 0);
    cyc("addi", 0, OP_ADDI, 6'h07, 0, 1, 2, O2, 6'h20);
    cyc("addi", 0, OP_ADDI, 6'h07, 0, 1, 4, PC|RW, 6'h20);

    cyc("lw", 0, OP_LW, 6'h00, 0, 1, 0, MR|IR, 0);
    cyc("lw", 0, OP_LW, 6'h00, 0, 1, 1, NO, 0);
    cyc("lw", 0, OP_LW, 6'h00, 0, 0, 2, O2, 6'h20);
    for (int i = 0; i < 3; i++)
      cyc("lw.wait", 0, OP_LW, 6'h00, 0, 0, 3, MR, 6'h20);
    cyc("lw", 0, OP_LW, 6'h00, 0, 1, 3, MR, 6'h20);
    cyc("lw", 0, OP_LW, 6'h00, 0, 1, 4, PC|RW|WB, 6'h20);

    cyc("sw", 0, OP_SW, 6'h00, 0, 1, 0, MR|IR, 0);
    cyc("sw", 0, OP_SW, 6'h00, 0, 1, 1, NO, 0);
    cyc("sw", 0, OP_SW, 6'h00, 0, 1, 2, O2, 6'h20);
    cyc("sw", 0, OP_SW, 6'h00, 0, 1, 3, MW|PC, 6'h20);

    cyc("beq1", 0, OP_BEQ, 6'h00, 1, 1, 0, MR|IR, 0);
    cyc("beq1", 0, OP_BEQ, 6'h00, 1, 1, 1, NO, 0);
    cyc("beq1", 0, OP_BEQ, 6'h00, 1, 1, 2, PC|BR, 6'h22);
    cyc("bne1", 0, OP_BNE, 6'h00, 1, 1, 0, MR|IR, 0);
    cyc("bne1", 0, OP_BNE, 6'h00, 1, 1, 1, NO, 0);
    cyc("bne1", 0, OP_BNE, 6'h00, 1, 1, 2, PC, 6'h22);
    cyc("beq0", 0, OP_BEQ, 6'h00, 0, 1, 0, MR|IR, 0);
    cyc("beq0", 0, OP_BEQ, 6'h00, 0, 1, 1, NO, 0);
    cyc("beq0", 0, OP_BEQ, 6'h00, 0, 1, 2, PC, 6'h22);
    cyc("bne0", 0, OP_BNE, 6'h00, 0, 1, 0, MR|IR, 0);
    cyc("bne0", 0, OP_BNE, 6'h00, 0, 1, 1, NO, 0);
    cyc("bne0", 0, OP_BNE, 6'h00, 0, 1, 2, PC|BR, 6'h22);

    cyc("j", 0, OP_J, 6'h00, 0, 1, 0, MR|IR, 0);
    cyc("j", 0, OP_J, 6'h00, 0, 1, 1, PC|JM, 0);

    cyc("ill", 0, 6'h3f, 6'h00, 0, 1, 0, MR|IR, 0);
    cyc("ill", 0, 6'h3f, 6'h00, 0, 1, 1, PC|IL, 0);

    cyc("jal", 0, OP_JAL, 6'h00, 0, 1, 0, MR|IR, 0);
`ifdef MC_CONTROL_JAL_EN
    cyc("jal", 0, OP_JAL, 6'h00, 0, 1, 1, NO, 0);
    cyc("jal", 0, OP_JAL, 6'h00, 0, 1, 4, PC|RW|LK|JM, 0);
`else
    cyc("jal", 0, OP_JAL, 6'h00, 0, 1, 1, PC|IL, 0);
`endif

    for (int i = 0; i < 4; i++)
      cyc("if.wait", 0, OP_J, 6'h00, 0, 0, 0, MR, 0);
    cyc("if.tmo", 0, OP_J, 6'h00, 0, 0, 0, IL, 0);
    cyc("if.short", 0, OP_J, 6'h00, 0, 0, 0, MR, 0);
    cyc("if.short", 0, OP_J, 6'h00, 0, 0, 0, MR, 0);
    cyc("if.short", 0, OP_J, 6'h00, 0, 1, 0, MR|IR, 0);
    cyc("if.short", 0, OP_J, 6'h00, 0, 1, 1, PC|JM, 0);

    cyc("ma.tmo", 0, OP_SW, 6'h00, 0, 1, 0, MR|IR, 0);
    cyc("ma.tmo", 0, OP_SW, 6'h00, 0, 1, 1, NO, 0);
    cyc("ma.tmo", 0, OP_SW, 6'h00, 0, 0, 2, O2, 6'h20);
    for (int i = 0; i < 4; i++)
      cyc("ma.wait", 0, OP_SW, 6'h00, 0, 0, 3, MW, 6'h20);
    cyc("ma.tmo", 0, OP_SW, 6'h00, 0, 0, 3, IL, 6'h20);
    cyc("ma.tmo", 0, OP_J, 6'h00, 0, 1, 0, MR|IR, 0);
    cyc("ma.tmo", 0, OP_J, 6'h00, 0, 1, 1, PC|JM, 0);

    cyc("sw.rst", 0, OP_SW, 6'h00, 0, 1, 0, MR|IR, 0);
    cyc("sw.rst", 0, OP_SW, 6'h00, 0, 1, 1, NO, 0);
    cyc("sw.rst", 0, OP_SW, 6'h00, 0, 0, 2, O2, 6'h20);
    cyc("sw.rst", 0, OP_SW, 6'h00, 0, 0, 3, MW, 6'h20);
    cyc("sw.rst", 1, OP_SW, 6'h00, 0, 0, 0, NO, 0);
    cyc("sw.rst", 0, OP_J, 6'h00, 0, 1, 0, MR|IR, 0);
    cyc("sw.rst", 0, OP_J, 6'h00, 0, 1, 1, PC|JM, 0);

    @(negedge clock);
    #1;
    check("drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
